// File: rtl/gpu_fe_pkg.sv
// Shared opcodes, instruction field positions and parameter defaults for the GPU command frontend.
package gpu_fe_pkg;
  localparam int INSTR_W_DEF    = 32;
  localparam int PC_W_DEF       = 16;
  localparam int VTX_W_DEF      = 28;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int OP_W         = 4;
  localparam int PTYPE_W      = 4;
  localparam int LOOP_CNT_LSB = 16;
  localparam int LOOP_CNT_W   = 12;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_START  = 4'd1,
    OP_VERTEX = 4'd2,
    OP_END    = 4'd3,
    OP_DRAW   = 4'd4,
    OP_LOOP   = 4'd5,
    OP_HALT   = 4'd6
  } opcode_e;
endpackage

// File: rtl/gpu_frontend_if.sv
// Decoded record stream from the frontend; master drives the record, slave drives out_ready.
interface gpu_frontend_if
  import gpu_fe_pkg::*;
#(
  parameter int VTX_W = VTX_W_DEF
);
  logic               out_valid;
  logic               out_ready;
  logic               StartPrimitive;
  logic               EndPrimitive;
  logic               Draw;
  logic [VTX_W-1:0]   Vertex;
  logic [PTYPE_W-1:0] PrimitiveType;

  modport master (output out_valid, StartPrimitive, EndPrimitive, Draw, Vertex, PrimitiveType,
                  input  out_ready);
  modport slave  (input  out_valid, StartPrimitive, EndPrimitive, Draw, Vertex, PrimitiveType,
                  output out_ready);
endinterface

// File: rtl/gpu_instr_fifo.sv
// Instruction queue: push visible at head next cycle; flush wins over push/pop.
// No internal backpressure; the producer must keep occupancy within DEPTH.
module gpu_instr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

// File: rtl/gpu_frontend.sv
// Fetches from a synchronous ROM, queues words and decodes them into one registered record per cycle.
// First record 3 edges after reset release; out_ready low holds the record and throttles fetch.
module gpu_frontend
  import gpu_fe_pkg::*;
#(
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int VTX_W      = VTX_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  gpu_frontend_if.master     out_if,
  output logic               Halted,
  output logic [PC_W-1:0]    PC
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]       pc_q;
  logic                  inflight_q, halted_q, loop_active_q;
  logic [LOOP_CNT_W-1:0] loop_cnt_q;
  logic                  out_valid_q, start_q, end_q, draw_q;
  logic [VTX_W-1:0]      vertex_q;
  logic [PTYPE_W-1:0]    ptype_q;

  logic [CW-1:0]         fifo_count;
  logic [INSTR_W-1:0]    fifo_head;
  logic                  fifo_empty, fifo_pop, fifo_push, fifo_flush;
  logic [OP_W-1:0]       head_op;
  logic [LOOP_CNT_W-1:0] head_cnt, loop_r;
  logic [CW:0]           occ;
  logic                  loop_pop, loop_taken, halt_pop, rec_pop;

  assign head_op  = fifo_head[INSTR_W-1 -: OP_W];
  assign head_cnt = fifo_head[LOOP_CNT_LSB +: LOOP_CNT_W];

  always_comb begin
    occ        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    imem_en    = Reset && !halted_q && (occ < (CW+1)'(FIFO_DEPTH));
    fifo_pop   = !fifo_empty && (!out_valid_q || out_if.out_ready);
    // Remaining iterations: first encounter derives it from the count field, later ones reuse loop_cnt.
    loop_r     = loop_active_q ? loop_cnt_q
                               : ((head_cnt == '0) ? '0 : head_cnt - LOOP_CNT_W'(1));
    loop_pop   = fifo_pop && (head_op == OP_LOOP);
    loop_taken = loop_pop && (loop_r != '0);
    halt_pop   = fifo_pop && (head_op == OP_HALT);
    rec_pop    = fifo_pop && ((head_op == OP_START) || (head_op == OP_VERTEX) ||
                              (head_op == OP_END)   || (head_op == OP_DRAW));
    fifo_flush = loop_taken || halt_pop;
    fifo_push  = inflight_q && !fifo_flush;
  end

  gpu_instr_fifo #(.W(INSTR_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (Reset),
    .push     (fifo_push),
    .push_dat (imem_data),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
    end else begin
      if (loop_taken)   pc_q <= fifo_head[PC_W-1:0];
      else if (imem_en) pc_q <= pc_q + PC_W'(1);
      // A flush also drops the fetch issued this cycle, so its data is never pushed.
      inflight_q <= imem_en && !fifo_flush;
      if (halt_pop) halted_q <= 1'b1;
      if (loop_pop) begin
        if (loop_r != '0) begin
          loop_cnt_q    <= loop_r - LOOP_CNT_W'(1);
          loop_active_q <= 1'b1;
        end else begin
          loop_active_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      draw_q      <= 1'b0;
      vertex_q    <= '0;
      ptype_q     <= '0;
    end else if (rec_pop) begin
      out_valid_q <= 1'b1;
      start_q     <= (head_op == OP_START);
      end_q       <= (head_op == OP_END);
      draw_q      <= (head_op == OP_DRAW);
      if (head_op == OP_START)  ptype_q  <= fifo_head[PTYPE_W-1:0];
      if (head_op == OP_VERTEX) vertex_q <= fifo_head[VTX_W-1:0];
    end else if (out_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign imem_addr             = pc_q;
  assign PC                    = pc_q;
  assign Halted                = halted_q;
  assign out_if.out_valid      = out_valid_q;
  assign out_if.StartPrimitive = start_q;
  assign out_if.EndPrimitive   = end_q;
  assign out_if.Draw           = draw_q;
  assign out_if.Vertex         = vertex_q;
  assign out_if.PrimitiveType  = ptype_q;
endmodule

// File: tb/tb_gpu_frontend.sv
// Scoreboard bench: an instruction-level interpreter of the ROM program predicts the record stream.
module tb_gpu_frontend;
  localparam int INSTR_W = 32, PC_W = 16, VTX_W = 28, FIFO_DEPTH = 4;

  logic               CLOCK_50 = 1'b0;
  logic               Reset = 1'b0;
  logic [PC_W-1:0]    imem_addr, PC;
  logic               imem_en, Halted;
  logic [INSTR_W-1:0] imem_data = '0;

  gpu_frontend_if #(.VTX_W(VTX_W)) out_if ();

  gpu_frontend #(.INSTR_W(INSTR_W), .PC_W(PC_W), .VTX_W(VTX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .imem_addr (imem_addr),
    .imem_en   (imem_en),
    .imem_data (imem_data),
    .out_if    (out_if.master),
    .Halted    (Halted),
    .PC        (PC)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  int          checks = 0, failures = 0;
  int          ready_mode = 0;
  bit          saw_active = 0;
  logic [31:0] rom [256];
  logic [63:0] exp_q [$];

  always @(posedge CLOCK_50) if (imem_en) imem_data <= rom[imem_addr[7:0]];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] rec(bit s, bit e, bit d, logic [3:0] pt, logic [27:0] v);
    return {1'b1, 24'd0, s, e, d, pt, 4'd0, v};
  endfunction

  function automatic logic [63:0] act_rec();
    bit is_v;
    is_v = !out_if.StartPrimitive && !out_if.EndPrimitive && !out_if.Draw;
    return {out_if.out_valid, 24'd0, out_if.StartPrimitive, out_if.EndPrimitive, out_if.Draw,
            out_if.PrimitiveType, 4'd0, is_v ? out_if.Vertex : 28'd0};
  endfunction

  function automatic logic [63:0] reset_vec();
    return {7'd0, dut.loop_active_q, out_if.out_valid, out_if.StartPrimitive, out_if.EndPrimitive,
            out_if.Draw, Halted, imem_en, out_if.PrimitiveType, out_if.Vertex, PC};
  endfunction

  function automatic logic [31:0] mk(logic [3:0] op, logic [27:0] f);
    return {op, f};
  endfunction

  // Walk the program as an ISA interpreter and list the records it must emit.
  task automatic build_expected();
    int pc = 0, cnt = 0, r;
    bit act = 0;
    logic [3:0]  pt = 4'd0;
    logic [31:0] w;
    for (int step = 0; step < 5000; step++) begin
      w = rom[pc % 256];
      case (w[31:28])
        4'd1: begin pt = w[3:0]; exp_q.push_back(rec(1, 0, 0, pt, 28'd0)); end
        4'd2: exp_q.push_back(rec(0, 0, 0, pt, w[27:0]));
        4'd3: exp_q.push_back(rec(0, 1, 0, pt, 28'd0));
        4'd4: exp_q.push_back(rec(0, 0, 1, pt, 28'd0));
        4'd5: begin
          r = act ? cnt : ((w[27:16] == 12'd0) ? 0 : int'(w[27:16]) - 1);
          if (r != 0) begin
            cnt = r - 1;
            act = 1;
            pc  = int'(w[15:0]);
            continue;
          end
          act = 0;
        end
        4'd6: return;
        default: ;
      endcase
      pc = (pc + 1) % 65536;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  task automatic start_prog();
    Reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    build_expected();
    Reset = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (dut.loop_active_q) saw_active = 1;
      done = Halted && (exp_q.size() == 0) && !out_if.out_valid;
    end
    repeat (5) tick();
    check(done, name, 64'(exp_q.size()), 64'd0);
    check(!imem_en && Halted, {name, "_halted"}, {62'd0, imem_en, Halted}, 64'd1);
  endtask

  // Monitor: checks each accepted record and that stalled records hold still.
  initial begin
    logic [63:0] held, a, e;
    bit stall = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!Reset) begin
        stall = 0;
      end else begin
        a = act_rec();
        if (stall) check(a == held, "hold_stable", a, held);
        stall = out_if.out_valid && !out_if.out_ready;
        held  = a;
        if (out_if.out_valid && out_if.out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_record", a, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check(a == e, "record", a, e);
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge CLOCK_50);
    #2;
    if (ready_mode == 1)      out_if.out_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 0) out_if.out_ready = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int len, p, t;
    logic [3:0] ops [7];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'hF, 4'd7};
    out_if.out_ready = 1'b1;
    clear_rom();
    #5;
    check(reset_vec() == 64'd0, "reset_state", reset_vec(), 64'd0);

    // Basic primitive, latency and halt
    rom[0] = mk(4'd1, 28'd3);   rom[1] = mk(4'd2, 28'h10); rom[2] = mk(4'd2, 28'h20);
    rom[3] = mk(4'd2, 28'h30);  rom[4] = mk(4'd3, 28'd0);  rom[5] = mk(4'd4, 28'd0);
    rom[6] = mk(4'd6, 28'd0);
    start_prog();
    repeat (2) @(posedge CLOCK_50);
    #1 check(!out_if.out_valid, "not_valid_after_2nd_edge", 64'(out_if.out_valid), 64'd0);
    @(posedge CLOCK_50);
    #1 check(out_if.out_valid && out_if.StartPrimitive && out_if.PrimitiveType == 4'd3,
             "first_record_3rd_edge", act_rec(), rec(1, 0, 0, 4'd3, 28'd0));
    wait_done("basic");

    // LOOP count 3
    clear_rom();
    rom[0] = mk(4'd2, 28'h1); rom[1] = mk(4'd5, {12'd3, 16'd0}); rom[2] = mk(4'd6, 28'd0);
    start_prog();
    wait_done("loop3");

    // LOOP count 0 and 1 fall through
    clear_rom();
    rom[0] = mk(4'd2, 28'h5); rom[1] = mk(4'd5, {12'd0, 16'd0}); rom[2] = mk(4'd2, 28'h6);
    rom[3] = mk(4'd5, {12'd1, 16'd0}); rom[4] = mk(4'd2, 28'h7); rom[5] = mk(4'd6, 28'd0);
    saw_active = 0;
    start_prog();
    wait_done("loop_fallthrough");
    check(!saw_active, "loop_active_stays_0", 64'(saw_active), 64'd0);

    // Illegal opcode decodes as NOP
    clear_rom();
    rom[0] = mk(4'd2, 28'hABC); rom[1] = mk(4'hF, 28'h2345); rom[2] = mk(4'd2, 28'hDEF);
    rom[3] = mk(4'd6, 28'd0);
    start_prog();
    wait_done("illegal_nop");

    // Downstream stall fills the queue
    clear_rom();
    rom[0] = mk(4'd1, 28'd9);
    for (int i = 1; i <= 6; i++) rom[i] = mk(4'd2, 28'(i * 17));
    rom[7] = mk(4'd3, 28'd0); rom[8] = mk(4'd4, 28'd0); rom[9] = mk(4'd6, 28'd0);
    ready_mode = 2;
    out_if.out_ready = 1'b1;
    start_prog();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge CLOCK_50);
      #1 found = out_if.out_valid;
    end
    #1 out_if.out_ready = 1'b0;
    check(found, "stall_first_record", 64'(found), 64'd1);
    repeat (10) tick();
    check(dut.fifo_count == FIFO_DEPTH && !imem_en, "stall_queue_full",
          {31'd0, imem_en, 32'(dut.fifo_count)}, 64'(FIFO_DEPTH));
    out_if.out_ready = 1'b1;
    ready_mode = 0;
    wait_done("stall_release");

    // Reset on the cycle a LOOP is taken
    clear_rom();
    rom[0] = mk(4'd2, 28'h1); rom[1] = mk(4'd5, {12'd3, 16'd0}); rom[2] = mk(4'd6, 28'd0);
    start_prog();
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      found = dut.loop_taken;
    end
    check(found, "loop_taken_seen", 64'(found), 64'd1);
    Reset = 1'b0;
    #1 check(reset_vec() == 64'd0, "reset_mid_loop", reset_vec(), 64'd0);
    start_prog();
    #1 check(PC == '0 && imem_en, "restart_pc0", {47'd0, imem_en, PC}, 64'h10000);
    wait_done("after_reset");

    // Randomized programs with random backpressure
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      clear_rom();
      len = $urandom_range(4, 12);
      for (int i = 0; i < len - 1; i++)
        rom[i] = mk(ops[$urandom_range(0, 6)], 28'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(1, len - 2);
        t = $urandom_range(0, p - 1);
        rom[p] = mk(4'd5, {12'($urandom_range(0, 3)), 16'(t)});
      end
      rom[len - 1] = mk(4'd6, 28'd0);
      start_prog();
      wait_done($sformatf("rand%0d", n));
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
